// File: rtl/fp_sub_dg_seq_if.sv
// Operand/result bundle between the controlling FSM and the multi-cycle FP subtractor.
interface fp_sub_dg_seq_if #(
  parameter int sig_width = 23,
  parameter int exp_width = 8
);
  localparam int W = sig_width + exp_width + 1;

  // start is taken only while the unit is idle and DG_ctrl=1; there is no ready.
  // busy covers the whole operation, complete pulses for one cycle when z/status change.
  logic         start;
  logic         DG_ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   rnd;
  logic         busy;
  logic         complete;
  logic [W-1:0] z;
  logic [7:0]   status;

  modport master (output start, DG_ctrl, a, b, rnd, input busy, complete, z, status);
  modport slave  (input start, DG_ctrl, a, b, rnd, output busy, complete, z, status);
endinterface

// File: rtl/fp_sub_dg_seq.sv
// Iterative IEEE-754 subtractor z = a - b with a freeze input (DG_ctrl) that holds all state.
module fp_sub_dg_seq #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int shift_step      = 4
) (
  input  logic           clk,
  input  logic           rst,
  fp_sub_dg_seq_if.slave bus,
  output logic [2:0]     dbg_state
);
  localparam int W    = sig_width + exp_width + 1;
  localparam int MW   = sig_width + 4;           // {1.frac, G, R, S}
  localparam int EW   = exp_width + 2;           // signed working exponent
  localparam int DW   = $clog2(MW + 1) + 1;
  localparam int MAXD = sig_width + 3;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << exp_width) - 1);
  localparam bit flush_denorm = (ieee_compliance == 0);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;
  state_t state, state_nx;

  logic [W-1:0]          a_r, b_r, res_z, z_r;
  logic [2:0]            rnd_r;
  logic                  sign_r, eff_sub_r, complete_r;
  logic signed [EW-1:0]  exp_r;
  logic [MW-1:0]         mx_r, my_r;
  logic [MW:0]           sum_r;
  logic [DW-1:0]         d_r;
  logic [7:0]            res_st, status_r;

  logic [exp_width-1:0]  ea, eb, ex, ey;
  logic [sig_width-1:0]  fa, fb, fx, fy;
  logic                  sa, sb, sx, sy, a_zero, b_zero, a_inf, b_inf, a_ge, spec_hit;
  logic [31:0]           diff_w;
  logic [DW-1:0]         d_c, step_c, lzc_c, amt_c;
  logic [MW-1:0]         mask_c, my_sh;
  logic [MW:0]           sum_c, norm_c;
  logic signed [EW-1:0]  exp_norm, e_out;
  logic                  g, r, s, inex, up, inf_ok;
  logic [sig_width+1:0]  mr;
  logic [sig_width-1:0]  frac_o;
  logic [W-1:0]          spec_z, rnd_z;
  logic [7:0]            spec_st, rnd_st;

  // Unpack: classify, order by magnitude, resolve inf/zero operands directly.
  always_comb begin
    sa = a_r[W-1]; ea = a_r[W-2:sig_width]; fa = a_r[sig_width-1:0];
    sb = b_r[W-1]; eb = b_r[W-2:sig_width]; fb = b_r[sig_width-1:0];
    a_inf  = &ea;
    b_inf  = &eb;
    a_zero = (ea == '0) && (flush_denorm || (fa == '0));
    b_zero = (eb == '0) && (flush_denorm || (fb == '0));
    a_ge   = {ea, fa} >= {eb, fb};
    sx = a_ge ? sa : sb;  ex = a_ge ? ea : eb;  fx = a_ge ? fa : fb;
    sy = a_ge ? sb : sa;  ey = a_ge ? eb : ea;  fy = a_ge ? fb : fa;
    diff_w = '0;
    diff_w[exp_width-1:0] = ex - ey;
    d_c = (diff_w > 32'(MAXD)) ? DW'(MAXD) : diff_w[DW-1:0];
    spec_hit = 1'b1;
    spec_z   = '0;
    spec_st  = '0;
    if (a_inf && b_inf) begin
      if (sa == sb) begin
        spec_z  = {sa, {exp_width{1'b1}}, {sig_width{1'b0}}};
        spec_st = 8'h02;
      end else begin
        spec_z  = {1'b0, {exp_width{1'b1}}, {sig_width{1'b0}}};
        spec_st = 8'h06;
      end
    end else if (a_inf) begin
      spec_z  = {sa, {exp_width{1'b1}}, {sig_width{1'b0}}};
      spec_st = 8'h02;
    end else if (b_inf) begin
      spec_z  = {sb, {exp_width{1'b1}}, {sig_width{1'b0}}};
      spec_st = 8'h02;
    end else if (a_zero && b_zero) begin
      spec_z  = {(sa == sb) ? sa : (rnd_r == 3'd3), {(W-1){1'b0}}};
      spec_st = 8'h01;
    end else if (a_zero) begin
      spec_z = b_r;
    end else if (b_zero) begin
      spec_z = a_r;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Align, add and normalise; bit 0 of the mantissa acts as the sticky bit.
  always_comb begin
    step_c = (d_r > DW'(shift_step)) ? DW'(shift_step) : d_r;
    mask_c = ~({MW{1'b1}} << step_c);
    my_sh  = (my_r >> step_c) | {{(MW-1){1'b0}}, |(my_r & mask_c)};
    sum_c  = eff_sub_r ? ({1'b0, mx_r} - {1'b0, my_r}) : ({1'b0, mx_r} + {1'b0, my_r});
    lzc_c  = DW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (sum_r[i]) lzc_c = DW'(MW - 1 - i);
    end
    amt_c = (lzc_c > DW'(shift_step)) ? DW'(shift_step) : lzc_c;
    if (sum_r[MW]) begin
      norm_c   = {1'b0, sum_r[MW:2], sum_r[1] | sum_r[0]};
      exp_norm = exp_r + EW'(1);
    end else begin
      norm_c   = sum_r << amt_c;
      exp_norm = exp_r - EW'(amt_c);
    end
  end

  // Round and pack, including overflow/underflow and the exact-zero sign rule.
  always_comb begin
    g    = sum_r[2];
    r    = sum_r[1];
    s    = sum_r[0];
    inex = g | r | s;
    case (rnd_r)
      3'd1:    up = 1'b0;
      3'd2:    up = ~sign_r & inex;
      3'd3:    up = sign_r & inex;
      3'd4:    up = g;
      3'd5:    up = inex;
      default: up = g & (r | s | sum_r[3]);
    endcase
    mr     = {1'b0, sum_r[MW-1:3]} + {{(sig_width+1){1'b0}}, up};
    frac_o = mr[sig_width+1] ? mr[sig_width:1] : mr[sig_width-1:0];
    e_out  = exp_r + {{(EW-1){1'b0}}, mr[sig_width+1]};
    inf_ok = (rnd_r == 3'd0) || (rnd_r == 3'd4) || (rnd_r == 3'd5) ||
             ((rnd_r == 3'd2) && !sign_r) || ((rnd_r == 3'd3) && sign_r);
    if (sum_r == '0) begin
      rnd_z  = {rnd_r == 3'd3, {(W-1){1'b0}}};
      rnd_st = 8'h01;
    end else if (e_out >= EMAX) begin
      rnd_z  = inf_ok ? {sign_r, {exp_width{1'b1}}, {sig_width{1'b0}}}
                      : {sign_r, {(exp_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
      rnd_st = {2'b00, 1'b1, 1'b1, 2'b00, inf_ok, 1'b0};
    end else if (e_out <= 0) begin
      rnd_z  = {sign_r, {(W-1){1'b0}}};
      rnd_st = 8'h29;
    end else begin
      rnd_z  = {sign_r, e_out[exp_width-1:0], frac_o};
      rnd_st = {2'b00, inex, 5'b00000};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start) state_nx = S_UNPACK;
      S_UNPACK: state_nx = spec_hit ? S_DONE : ((d_c != '0) ? S_ALIGN : S_ADD);
      S_ALIGN:  if (d_r == step_c) state_nx = S_ADD;
      // NORM is skipped when the sum is zero or already normalised.
      S_ADD:    state_nx = (sum_c[MW] || ((sum_c[MW-1:0] != '0) && !sum_c[MW-1])) ? S_NORM : S_ROUND;
      S_NORM:   if (sum_r[MW] || (amt_c == lzc_c)) state_nx = S_ROUND;
      S_ROUND:  state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else if (bus.DG_ctrl) state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; rnd_r <= '0; sign_r <= 1'b0; eff_sub_r <= 1'b0;
      exp_r <= '0; mx_r <= '0; my_r <= '0; sum_r <= '0; d_r <= '0;
      res_z <= '0; res_st <= '0; z_r <= '0; status_r <= '0;
    end else if (bus.DG_ctrl) begin
      case (state)
        S_IDLE: if (bus.start) begin
          a_r   <= bus.a;
          b_r   <= {~bus.b[W-1], bus.b[W-2:0]};
          rnd_r <= (bus.rnd > 3'd5) ? 3'd0 : bus.rnd;
        end
        S_UNPACK: begin
          sign_r    <= sx;
          eff_sub_r <= sx ^ sy;
          exp_r     <= $signed({2'b00, ex});
          mx_r      <= {1'b1, fx, 3'b000};
          my_r      <= {1'b1, fy, 3'b000};
          d_r       <= d_c;
          res_z     <= spec_z;
          res_st    <= spec_st;
        end
        S_ALIGN: begin
          my_r <= my_sh;
          d_r  <= d_r - step_c;
        end
        S_ADD:   sum_r <= sum_c;
        S_NORM: begin
          sum_r <= norm_c;
          exp_r <= exp_norm;
        end
        S_ROUND: begin
          res_z  <= rnd_z;
          res_st <= rnd_st;
        end
        S_DONE: begin
          z_r      <= res_z;
          status_r <= res_st;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) complete_r <= 1'b0;
    else     complete_r <= bus.DG_ctrl && (state == S_DONE);
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.complete = complete_r;
  assign bus.z        = z_r;
  assign bus.status   = status_r;
  assign dbg_state    = state;
endmodule
